// File: rtl/uart_block_receiver.sv
// Parses UART RX frames [bytecount:4 LE][address:4 LE][payload:BLOCK_BYTES] and commits each payload to bmem.
// Define UART_RX_TIMEOUT_EN to add an inter-byte idle timeout of TIMEOUT_CYCLES clocks.
module uart_block_receiver #(
  parameter int BITWIDTH       = 32,
  parameter int BLOCK_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     bmem_wr_en,
  output logic [BITWIDTH-1:0]      bmem_wr_addr,
  output logic [8*BLOCK_BYTES-1:0] bmem_wr_data,
  input  logic                     bmem_wr_ack,
  output logic                     pkt_done,
  output logic                     pkt_error,
  output logic                     busy
);

  localparam int CNT_MAX = (BLOCK_BYTES > 4) ? BLOCK_BYTES : 4;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [BITWIDTH-1:0] FRAME_COUNT = BITWIDTH'(4 + BLOCK_BYTES);
  localparam logic [CNT_W-1:0]    LAST_FIELD  = CNT_W'(3);
  localparam logic [CNT_W-1:0]    LAST_DATA   = CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    RX_COUNT = 3'd0,
    RX_ADDR  = 3'd1,
    RX_DATA  = 3'd2,
    COMMIT   = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  if (BITWIDTH < 32 || BLOCK_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_block_receiver: BITWIDTH must be >= 32, BLOCK_BYTES and TIMEOUT_CYCLES >= 1");
  end

  state_t              state_r;
  logic [CNT_W-1:0]    byte_cnt_r;
  logic [23:0]         count_r;
  logic [BITWIDTH-1:0] remaining_r;
  logic                accept_s;
  logic [BITWIDTH-1:0] count_full_s;

  assign accept_s     = rx_valid && rx_ready;
  // The 4th bytecount byte is still on rx_data when the frame length is judged.
  assign count_full_s = BITWIDTH'({rx_data, count_r});

`ifdef UART_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_r;
  logic              idle_active_s;
  logic              timeout_s;

  assign idle_active_s = (state_r == RX_ADDR) || (state_r == RX_DATA) || (state_r == DRAIN) ||
                         ((state_r == RX_COUNT) && (byte_cnt_r != CNT_W'(0)));
  assign timeout_s     = idle_active_s && !accept_s && (idle_r == IDLE_W'(TIMEOUT_CYCLES - 1));
`endif

  // Frame parser FSM with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= RX_COUNT;
      byte_cnt_r   <= CNT_W'(0);
      count_r      <= 24'd0;
      remaining_r  <= BITWIDTH'(0);
      rx_ready     <= 1'b1;
      bmem_wr_en   <= 1'b0;
      bmem_wr_addr <= BITWIDTH'(0);
      bmem_wr_data <= {(8*BLOCK_BYTES){1'b0}};
      pkt_done     <= 1'b0;
      pkt_error    <= 1'b0;
      busy         <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      idle_r       <= IDLE_W'(0);
`endif
    end else begin
      pkt_done  <= 1'b0;
      pkt_error <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      idle_r <= (accept_s || !idle_active_s) ? IDLE_W'(0) : idle_r + IDLE_W'(1);
      if (timeout_s) begin
        state_r     <= RX_COUNT;
        byte_cnt_r  <= CNT_W'(0);
        remaining_r <= BITWIDTH'(0);
        pkt_error   <= 1'b1;
        busy        <= 1'b0;
        idle_r      <= IDLE_W'(0);
      end else
`endif
      begin
        case (state_r)
          RX_COUNT: begin
            if (accept_s) begin
              if (byte_cnt_r == LAST_FIELD) begin
                byte_cnt_r <= CNT_W'(0);
                if (count_full_s == FRAME_COUNT) begin
                  state_r <= RX_ADDR;
                  busy    <= 1'b1;
                end else begin
                  pkt_error   <= 1'b1;
                  remaining_r <= count_full_s;
                  if (count_full_s == BITWIDTH'(0)) begin
                    state_r <= RX_COUNT;
                    busy    <= 1'b0;
                  end else begin
                    state_r <= DRAIN;
                    busy    <= 1'b1;
                  end
                end
              end else begin
                for (int k = 0; k < 3; k++) begin
                  if (byte_cnt_r == CNT_W'(k)) count_r[8*k +: 8] <= rx_data;
                end
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                busy       <= 1'b1;
              end
            end
          end

          RX_ADDR: begin
            if (accept_s) begin
              // Block addresses are word aligned; the first byte also clears any bits above 32.
              if (byte_cnt_r == CNT_W'(0)) begin
                bmem_wr_addr <= BITWIDTH'({rx_data[7:2], 2'b00});
              end else begin
                for (int k = 1; k < 4; k++) begin
                  if (byte_cnt_r == CNT_W'(k)) bmem_wr_addr[8*k +: 8] <= rx_data;
                end
              end
              if (byte_cnt_r == LAST_FIELD) begin
                byte_cnt_r <= CNT_W'(0);
                state_r    <= RX_DATA;
              end else begin
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
              end
            end
          end

          RX_DATA: begin
            if (accept_s) begin
              for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (byte_cnt_r == CNT_W'(k)) bmem_wr_data[8*k +: 8] <= rx_data;
              end
              if (byte_cnt_r == LAST_DATA) begin
                byte_cnt_r <= CNT_W'(0);
                state_r    <= COMMIT;
                rx_ready   <= 1'b0;
                bmem_wr_en <= 1'b1;
              end else begin
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
              end
            end
          end

          COMMIT: begin
            if (bmem_wr_ack) begin
              bmem_wr_en <= 1'b0;
              pkt_done   <= 1'b1;
              rx_ready   <= 1'b1;
              busy       <= 1'b0;
              state_r    <= RX_COUNT;
            end
          end

          DRAIN: begin
            if (remaining_r == BITWIDTH'(0)) begin
              state_r <= RX_COUNT;
              busy    <= 1'b0;
            end else if (accept_s) begin
              if (remaining_r == BITWIDTH'(1)) begin
                remaining_r <= BITWIDTH'(0);
                state_r     <= RX_COUNT;
                busy        <= 1'b0;
              end else begin
                remaining_r <= remaining_r - BITWIDTH'(1);
              end
            end
          end

          default: begin
            state_r    <= RX_COUNT;
            byte_cnt_r <= CNT_W'(0);
            rx_ready   <= 1'b1;
            bmem_wr_en <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
